// File: rtl/bf16_pow2_upscale.sv
// Streaming bf16 power-of-two scaler: out = in * 2^shift_amt over a two-stage
// valid/ready pipeline, with overflow/underflow flags and saturating event counters.
module bf16_pow2_upscale #(
   parameter int EXP_SIZE      = 8,
   parameter int MANTISSA_SIZE = 7,
   parameter int SHIFT_W       = 8,
   parameter int CNT_W         = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [EXP_SIZE+MANTISSA_SIZE:0]   in_data,
   input  logic signed [SHIFT_W-1:0]         shift_amt,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [EXP_SIZE+MANTISSA_SIZE:0]   out_data,
   output logic                              out_ovf,
   output logic                              out_unf,
   input  logic                              cnt_clr,
   output logic [CNT_W-1:0]                  ovf_count,
   output logic [CNT_W-1:0]                  unf_count
);

   localparam int DW    = 1 + EXP_SIZE + MANTISSA_SIZE;
   localparam int SUM_W = ((EXP_SIZE > SHIFT_W) ? EXP_SIZE : SHIFT_W) + 2;
   localparam logic signed [SUM_W-1:0] SUM_INF  = SUM_W'((1 << EXP_SIZE) - 1);
   localparam logic signed [SUM_W-1:0] SUM_ZERO = '0;

   typedef struct packed {
      logic                     sign;
      logic [EXP_SIZE-1:0]      exp;
      logic [MANTISSA_SIZE-1:0] man;
      logic                     is_zero;
      logic                     is_special;
      logic [SUM_W-1:0]         sum;
   } s1_t;

   logic [2:1]        vld_pipe;
   logic              s1_advance;
   logic              out_hs;
   s1_t               s1_d, s1_q;
   logic [DW-1:0]     res_data;
   logic              res_ovf, res_unf;
   logic signed [SUM_W-1:0] s1_sum;

   assign s1_advance = !vld_pipe[2] || out_ready;
   assign in_ready   = !vld_pipe[1] || s1_advance;
   assign out_valid  = vld_pipe[2];
   assign out_hs     = vld_pipe[2] && out_ready;

   always_comb begin
      s1_d            = '0;
      s1_d.sign       = in_data[DW-1];
      s1_d.exp        = in_data[DW-2:MANTISSA_SIZE];
      s1_d.man        = in_data[MANTISSA_SIZE-1:0];
      s1_d.is_zero    = (s1_d.exp == '0);
      s1_d.is_special = &s1_d.exp;
      s1_d.sum        = $signed({{(SUM_W-EXP_SIZE){1'b0}}, s1_d.exp})
                      + $signed({{(SUM_W-SHIFT_W){shift_amt[SHIFT_W-1]}}, shift_amt});
   end

   assign s1_sum = $signed(s1_q.sum);

   // Zero/denormal and Inf/NaN take priority over the range checks on the sum.
   always_comb begin
      res_data = {s1_q.sign, s1_sum[EXP_SIZE-1:0], s1_q.man};
      res_ovf  = 1'b0;
      res_unf  = 1'b0;
      if (s1_q.is_zero) begin
         res_data = {s1_q.sign, {(DW-1){1'b0}}};
      end else if (s1_q.is_special) begin
         res_data = {s1_q.sign, s1_q.exp, s1_q.man};
      end else if (s1_sum >= SUM_INF) begin
         res_data = {s1_q.sign, {EXP_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
         res_ovf  = 1'b1;
      end else if (s1_sum <= SUM_ZERO) begin
         res_data = {s1_q.sign, {(DW-1){1'b0}}};
         res_unf  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         out_data <= '0;
         out_ovf  <= 1'b0;
         out_unf  <= 1'b0;
      end else begin
         if (in_ready) vld_pipe[1] <= in_valid;
         if (in_valid && in_ready) s1_q <= s1_d;
         if (s1_advance) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
               out_data <= res_data;
               out_ovf  <= res_ovf;
               out_unf  <= res_unf;
            end
         end
      end
   end

   // Clear wins over a same-cycle increment; counts stick at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n || cnt_clr) begin
         ovf_count <= '0;
         unf_count <= '0;
      end else begin
         if (out_hs && out_ovf && !(&ovf_count)) ovf_count <= ovf_count + CNT_W'(1);
         if (out_hs && out_unf && !(&unf_count)) unf_count <= unf_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_bf16_pow2_upscale.sv
// Scoreboard bench for bf16_pow2_upscale: directed vectors, backpressure, reset
// mid-stream, random traffic and counter saturation/clear.
module tb_bf16_pow2_upscale;

   localparam int CNT_W = 16;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [15:0]       in_data = '0;
   logic signed [7:0] shift_amt = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [15:0]       out_data;
   logic              out_ovf, out_unf;
   logic              cnt_clr = 1'b0;
   logic [CNT_W-1:0]  ovf_count, unf_count;

   always #5 clk = ~clk;

   bf16_pow2_upscale #(.EXP_SIZE(8), .MANTISSA_SIZE(7), .SHIFT_W(8), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .shift_amt(shift_amt), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .out_unf(out_unf),
      .cnt_clr(cnt_clr), .ovf_count(ovf_count), .unf_count(unf_count)
   );

   typedef struct packed {
      logic [15:0] d;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0, n_fail = 0;
   int   mdl_ovf = 0, mdl_unf = 0;
   logic tx_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] d, input int sh);
      exp_t r;
      int   e, sum;
      r   = '0;
      e   = int'(d[14:7]);
      sum = e + sh;
      if (e == 0)            r.d = {d[15], 15'h0};
      else if (e == 255)     r.d = d;
      else if (sum >= 255) begin r.d = {d[15], 8'hFF, 7'h0}; r.ovf = 1'b1; end
      else if (sum <= 0)   begin r.d = {d[15], 15'h0};       r.unf = 1'b1; end
      else                   r.d = {d[15], sum[7:0], d[6:0]};
      return r;
   endfunction

   // Caller is aligned just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [15:0] d, input int sh, input exp_t e);
      in_valid  = 1'b1;
      in_data   = d;
      shift_amt = 8'(sh);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
      end
      chk("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic send_m(input logic [15:0] d, input int sh);
      send(d, sh, model(d, sh));
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) return;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // Output monitor: pops the scoreboard on every output handshake and tracks counters.
   always @(negedge clk) begin
      exp_t e;
      logic hs_ovf, hs_unf;
      hs_ovf = 1'b0;
      hs_unf = 1'b0;
      if (!rst_n) begin
         sb.delete();
         mdl_ovf = 0;
         mdl_unf = 0;
      end else begin
         chk("ovf_count", 32'(ovf_count), 32'(mdl_ovf));
         chk("unf_count", 32'(unf_count), 32'(mdl_unf));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("out_data", 32'(out_data), 32'(e.d));
               chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
               chk("out_unf", 32'(out_unf), 32'(e.unf));
               hs_ovf = e.ovf;
               hs_unf = e.unf;
            end
         end
         if (cnt_clr) begin
            mdl_ovf = 0;
            mdl_unf = 0;
         end else begin
            if (hs_ovf && mdl_ovf < CMAX) mdl_ovf++;
            if (hs_unf && mdl_unf < CMAX) mdl_unf++;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [15:0] t_in  [12] = '{16'hC040, 16'h7F00, 16'hFF00, 16'h0080, 16'h8000, 16'h7FC1,
                               16'h0001, 16'h4049, 16'h3F80, 16'h3F80, 16'h4000, 16'h3F80};
   int          t_sh  [12] = '{-2, 1, 5, -1, 7, 5, 0, 0, -127, 127, 127, -128};
   logic [15:0] t_out [12] = '{16'hBF40, 16'h7F80, 16'hFF80, 16'h0000, 16'h8000, 16'h7FC1,
                               16'h0000, 16'h4049, 16'h0000, 16'h7F00, 16'h7F80, 16'h0000};
   logic [1:0]  t_flg [12] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00,
                               2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};

   initial begin
      exp_t        e;
      logic [15:0] hold;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_flags", 32'({out_ovf, out_unf}), 32'd0);
      chk("rst_ovf_count", 32'(ovf_count), 32'd0);
      chk("rst_unf_count", 32'(unf_count), 32'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;

      // 1.0 * 2^3 = 8.0, out_valid in the second cycle after the handshake
      send(16'h3F80, 3, exp_t'({16'h4100, 2'b00}));
      @(negedge clk);
      chk("lat_cycle1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_cycle2", 32'(out_valid), 32'd1);
      drain();

      for (int i = 0; i < 12; i++) begin
         e.d = t_out[i];
         {e.ovf, e.unf} = t_flg[i];
         send(t_in[i], t_sh[i], e);
      end
      drain();
      chk("dir_ovf_total", 32'(ovf_count), 32'd3);
      chk("dir_unf_total", 32'(unf_count), 32'd3);

      // Backpressure: two beats fill the pipe, then input stalls and output holds
      out_ready = 1'b0;
      send(16'h3F80, 1, exp_t'({16'h4000, 2'b00}));
      send(16'h3F80, 2, exp_t'({16'h4080, 2'b00}));
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h4000);
      hold = out_data;
      repeat (2) begin
         @(negedge clk);
         chk("bp_hold_data", 32'(out_data), 32'(hold));
         chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(16'h3F80, 3, exp_t'({16'h4100, 2'b00}));
      send(16'h3F80, 4, exp_t'({16'h4180, 2'b00}));
      drain();

      // Random traffic under random backpressure
      fork
         begin
            for (int i = 0; i < 60; i++)
               send_m(16'($urandom), int'($urandom_range(0, 40)) - 20);
            tx_done = 1'b1;
         end
         begin
            for (int i = 0; i < 3000 && !tx_done; i++) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      // Reset with two beats in flight
      out_ready = 1'b0;
      send(16'h7F00, 1, exp_t'({16'h7F80, 2'b10}));
      send(16'h0080, -1, exp_t'({16'h0000, 2'b01}));
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_ovf_count", 32'(ovf_count), 32'd0);
      chk("midrst_unf_count", 32'(unf_count), 32'd0);
      out_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("midrst_no_stale", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;

      // Drive the overflow counter past all-ones
      for (int i = 0; i < CMAX + 4; i++) send(16'h7F00, 1, exp_t'({16'h7F80, 2'b10}));
      drain();
      chk("ovf_saturated", 32'(ovf_count), 32'(CMAX));

      // Clear coinciding with an overflow handshake
      send(16'h7F00, 1, exp_t'({16'h7F80, 2'b10}));
      @(posedge clk);
      #1;
      cnt_clr = 1'b1;
      @(negedge clk);
      chk("clr_hs_present", 32'(out_valid && out_ready && out_ovf), 32'd1);
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      chk("clr_priority", 32'(ovf_count), 32'd0);
      send(16'h7F00, 1, exp_t'({16'h7F80, 2'b10}));
      drain();
      chk("post_clr_count", 32'(ovf_count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bf16_pow2_upscale.md
Name: bf16_pow2_upscale

Overview:
- Streaming bfloat16 exponent scaler: out = in × 2^shift_amt, where a signed shift_amt > 0 scales up.
- Counterpart of the softmax right-shift stage. It re-expands normalised values, for example 2^k reconstruction after exponent splitting and denormalisation in softmax and normalisation paths.
- 2-stage pipeline with valid/ready handshake on both sides.
- Flags overflow and underflow per result and keeps saturating event counters.

Parameters:
- EXP_SIZE, 8, exponent field width.
- MANTISSA_SIZE, 7, mantissa field width; data width = 1 + EXP_SIZE + MANTISSA_SIZE = 16.
- SHIFT_W, 8, width of signed shift_amt.
- CNT_W, 16, width of overflow/underflow event counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  16  bf16 operand: [15] sign, [14:7] exponent, [6:0] mantissa.
- shift_amt  in  SHIFT_W  signed power-of-two scale, sampled with in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  16  scaled bf16 result.
- out_ovf  out  1  result saturated to infinity; valid with out_valid.
- out_unf  out  1  result flushed to zero; valid with out_valid.
- cnt_clr  in  1  synchronous clear of both counters.
- ovf_count  out  CNT_W  saturating count of overflow results delivered.
- unf_count  out  CNT_W  saturating count of underflow results delivered.

Behaviour:
- Reset while rst_n=0 at a clock edge:
  - both stage valids, out_valid, out_data, out_ovf, out_unf, ovf_count and unf_count all go to 0;
  - in-flight beats are discarded and no partial output is issued.
- Handshake:
  - transfer occurs when valid && ready;
  - out_valid and out_data/flags stay stable while out_valid && !out_ready;
  - in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready (combinational path from out_ready is allowed).
- Throughput and latency:
  - throughput is 1 beat/cycle;
  - latency is 2 cycles from input handshake to out_valid with no backpressure;
  - order is preserved and no beat is lost or duplicated.
- Stage 1 (registered): captures sign, exp, mantissa and class, then computes sum = zero-extend(exp) + sign-extend(shift_amt) at 10-bit signed width.
- Stage 2 (registered), classified in priority order:
  - exp = 0 (zero or denormal): out = {sign, 0}; flags 0. Denormals flush to signed zero without setting the underflow flag.
  - exp = all-ones (Inf/NaN): out = in_data unchanged; flags 0.
  - sum >= 255: out = {sign, 8'hFF, 7'h0} (signed infinity); out_ovf = 1.
  - sum <= 0: out = {sign, 0}; out_unf = 1.
  - otherwise: out = {sign, sum[7:0], mantissa}. The mantissa is never altered and there is no rounding.
  - shift_amt = 0 returns the input bit-exactly, except that denormals flush to zero.
- Counters:
  - increment on the output handshake when the corresponding flag is 1;
  - hold at all-ones (saturating);
  - cnt_clr has priority over an increment in the same cycle, giving 0 next cycle;
  - cnt_clr does not affect the datapath.
- Simultaneous events:
  - with stage 2 full and out_ready=1, a new input and a stage-1 advance happen in the same cycle;
  - with out_ready=0 and both stages full, in_ready=0.

Test Plan:
- Scale up: 0x3F80 (1.0), shift +3 -> 0x4100 (8.0), flags 0, out_valid exactly 2 cycles after handshake.
- Scale down with negative sign: 0xC040 (-3.0), shift -2 -> 0xBF40 (-0.75).
- Overflow: 0x7F00, shift +1 -> 0x7F80, out_ovf=1, ovf_count 0->1. Also 0xFF00, shift +5 -> 0xFF80.
- Underflow and specials:
  - 0x0080, shift -1 -> 0x0000 with out_unf=1;
  - 0x8000, shift +7 -> 0x8000 with flags 0;
  - 0x7FC1, shift +5 -> 0x7FC1;
  - 0x0001 (denormal), shift 0 -> 0x0000.
- Backpressure: stream 4 beats back-to-back with out_ready=0 for 3 cycles.
  - in_ready falls after 2 beats are accepted and out_data is held stable.
  - When out_ready=1, all 4 results emerge in order with none lost.
- Reset mid-stream with 2 beats in flight: rst_n=0 for 1 cycle -> out_valid=0 and counters 0, with no stale result afterwards. Saturate ovf_count at 0xFFFF and hold it there. cnt_clr together with an overflow handshake -> count reads 0.
